// File: rtl/sound_frame_sequencer_if.sv
// Bus between the frame sequencer and the four sound channels plus the NR52
// register read path. Clock and reset stay plain ports on the modules.
//
// Signalling: there is no valid/ready handshake on this bus. I_MASTER_EN and
// I_CH_ON are levels the consumer may change on any cycle. The three tick
// outputs and O_CH_RESET are single-cycle strobes that the channels must act
// on in the cycle they are high; they are never stretched or held off.
// O_STEP, O_NR52, O_RUNNING and state_dbg are levels valid every cycle.
interface sound_frame_sequencer_if;
    logic       I_MASTER_EN;
    logic [3:0] I_CH_ON;
    logic       O_LENGTH_TICK;
    logic       O_SWEEP_TICK;
    logic       O_ENV_TICK;
    logic [2:0] O_STEP;
    logic       O_CH_RESET;
    logic [7:0] O_NR52;
    logic       O_RUNNING;
    logic [1:0] state_dbg;

    // Sequencer side: owns all timing outputs.
    modport master (
        input  I_MASTER_EN,
        input  I_CH_ON,
        output O_LENGTH_TICK,
        output O_SWEEP_TICK,
        output O_ENV_TICK,
        output O_STEP,
        output O_CH_RESET,
        output O_NR52,
        output O_RUNNING,
        output state_dbg
    );

    // Consumer side: register file / channels / bench.
    modport slave (
        output I_MASTER_EN,
        output I_CH_ON,
        input  O_LENGTH_TICK,
        input  O_SWEEP_TICK,
        input  O_ENV_TICK,
        input  O_STEP,
        input  O_CH_RESET,
        input  O_NR52,
        input  O_RUNNING,
        input  state_dbg
    );
endinterface

// File: rtl/sound_frame_sequencer.sv
// Frame sequencer for the four sound channels: divides I_CLK down to the
// 512 Hz frame step, walks the 8-step frame, and emits one-cycle length,
// sweep and envelope ticks. Also sequences the NR52 master enable: power-off
// clears the channels through a one-cycle CLEAR state, and power-on restarts
// the frame from step 0 with a freshly zeroed divider.
module sound_frame_sequencer #(
    parameter int STEP_DIV = 8192,  // I_CLK cycles per frame step, 2..65535
    parameter int DIV_W    = 16     // 2**DIV_W must be >= STEP_DIV
) (
    input  logic                    I_CLK,
    input  logic                    I_RESET,
    sound_frame_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    state_t           state_q;
    state_t           state_nxt;

    logic             master_en_q;     // registered I_MASTER_EN
    logic             master_en_prev;  // master_en_q one cycle earlier
    logic             rise;
    logic             fall;
    logic             rise_pend_q;     // rising edge that landed inside CLEAR

    logic [DIV_W-1:0] div_q;
    logic [2:0]       step_q;
    logic [2:0]       step_inc;
    logic             div_wrap;
    logic             advance;

    logic             length_tick_q;
    logic             sweep_tick_q;
    logic             env_tick_q;

    logic             running;
    logic             ch_reset;

    // Edges are taken on the registered copy so the FSM never sees a raw
    // asynchronous register write.
    assign rise = master_en_q & ~master_en_prev;
    assign fall = ~master_en_q & master_en_prev;

    // Capture master enable and its history; remember a re-enable that
    // arrives while CLEAR is still draining so OFF can act on it.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            master_en_q    <= 1'b0;
            master_en_prev <= 1'b0;
            rise_pend_q    <= 1'b0;
        end else begin
            master_en_q    <= bus.I_MASTER_EN;
            master_en_prev <= master_en_q;
            rise_pend_q    <= (state_q == ST_CLEAR) && rise;
        end
    end

    // FSM state register.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM next-state logic. A falling edge in RUN wins over any wrap.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_OFF: begin
                if (rise || (rise_pend_q && master_en_q)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fall) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_OFF;
            end
            default: begin
                state_nxt = ST_OFF;
            end
        endcase
    end

    // FSM outputs: running flag and the channel clear strobe.
    always_comb begin
        running  = 1'b0;
        ch_reset = 1'b0;
        case (state_q)
            ST_RUN:   running  = 1'b1;
            ST_CLEAR: ch_reset = 1'b1;
            default: begin
                running  = 1'b0;
                ch_reset = 1'b0;
            end
        endcase
    end

    // The divider only advances in RUN while no power-off is being seen;
    // everywhere else it and the step counter are parked at zero, so RUN is
    // always entered from divider 0 / step 0.
    assign advance  = (state_q == ST_RUN) && !fall;
    assign div_wrap = (div_q == DIV_LAST);
    assign step_inc = step_q + 3'd1;

    // Divider, step counter and tick registers. Ticks are decoded from the
    // step value being entered and are high for the single cycle after the
    // wrap edge.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            div_q         <= '0;
            step_q        <= 3'd0;
            length_tick_q <= 1'b0;
            sweep_tick_q  <= 1'b0;
            env_tick_q    <= 1'b0;
        end else begin
            length_tick_q <= 1'b0;
            sweep_tick_q  <= 1'b0;
            env_tick_q    <= 1'b0;
            if (advance) begin
                if (div_wrap) begin
                    div_q         <= '0;
                    step_q        <= step_inc;
                    length_tick_q <= ~step_inc[0];
                    sweep_tick_q  <= (step_inc[1:0] == 2'b10);
                    env_tick_q    <= (step_inc == 3'd7);
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end else begin
                div_q  <= '0;
                step_q <= 3'd0;
            end
        end
    end

    assign bus.O_LENGTH_TICK = length_tick_q;
    assign bus.O_SWEEP_TICK  = sweep_tick_q;
    assign bus.O_ENV_TICK    = env_tick_q;
    assign bus.O_STEP        = step_q;
    assign bus.O_CH_RESET    = ch_reset;
    assign bus.O_RUNNING     = running;
    assign bus.O_NR52        = {master_en_q, 3'b111, bus.I_CH_ON};
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_sound_frame_sequencer.sv
// Directed bench for sound_frame_sequencer with STEP_DIV=4.
module tb_sound_frame_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    sound_frame_sequencer_if sfs_if ();

    sound_frame_sequencer #(
        .STEP_DIV(4),
        .DIV_W   (16)
    ) dut (
        .I_CLK  (clk),
        .I_RESET(rst),
        .bus    (sfs_if)
    );

    // Clock: 10 time-unit period; everything is driven and sampled on negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        int   n_len;
        int   n_sweep;
        int   n_env;
        int   n_adj;
        logic p_len;
        logic p_sweep;
        logic p_env;
        logic [2:0] s_exp;
        logic wrap;

        checks   = 0;
        failures = 0;
        n_len = 0; n_sweep = 0; n_env = 0; n_adj = 0;
        p_len = 1'b0; p_sweep = 1'b0; p_env = 1'b0;

        rst = 1'b1;
        sfs_if.I_MASTER_EN = 1'b0;
        sfs_if.I_CH_ON     = 4'b0000;
        repeat (2) cyc();

        // Reset state
        chk("rst_running", sfs_if.O_RUNNING, 0);
        chk("rst_step", sfs_if.O_STEP, 0);
        chk("rst_len", sfs_if.O_LENGTH_TICK, 0);
        chk("rst_sweep", sfs_if.O_SWEEP_TICK, 0);
        chk("rst_env", sfs_if.O_ENV_TICK, 0);
        chk("rst_chreset", sfs_if.O_CH_RESET, 0);
        chk("rst_nr52", sfs_if.O_NR52, 8'h70);
        chk("rst_state", sfs_if.state_dbg, 0);
        rst = 1'b0;
        cyc();
        chk("off_idle_running", sfs_if.O_RUNNING, 0);

        // Power on: RUN two cycles after the enable write
        sfs_if.I_MASTER_EN = 1'b1;
        cyc();
        chk("on_delay1_running", sfs_if.O_RUNNING, 0);
        cyc();
        chk("on_entry_running", sfs_if.O_RUNNING, 1);
        chk("on_entry_step", sfs_if.O_STEP, 0);
        chk("on_entry_len", sfs_if.O_LENGTH_TICK, 0);
        chk("on_entry_nr52", sfs_if.O_NR52, 8'hF0);

        // 64 frame steps: step advances every 4 cycles, ticks on the step entered
        for (int c = 1; c <= 256; c++) begin
            cyc();
            s_exp = 3'((c / 4) % 8);
            wrap  = (c % 4) == 0;
            chk("run_step", sfs_if.O_STEP, s_exp);
            chk("run_len", sfs_if.O_LENGTH_TICK, wrap && (s_exp[0] == 1'b0));
            chk("run_sweep", sfs_if.O_SWEEP_TICK, wrap && (s_exp == 3'd2 || s_exp == 3'd6));
            chk("run_env", sfs_if.O_ENV_TICK, wrap && (s_exp == 3'd7));
            if (sfs_if.O_LENGTH_TICK) n_len++;
            if (sfs_if.O_SWEEP_TICK)  n_sweep++;
            if (sfs_if.O_ENV_TICK)    n_env++;
            if ((sfs_if.O_LENGTH_TICK && p_len) || (sfs_if.O_SWEEP_TICK && p_sweep) ||
                (sfs_if.O_ENV_TICK && p_env)) n_adj++;
            p_len   = sfs_if.O_LENGTH_TICK;
            p_sweep = sfs_if.O_SWEEP_TICK;
            p_env   = sfs_if.O_ENV_TICK;
        end
        chk("count_len", n_len, 32);
        chk("count_sweep", n_sweep, 16);
        chk("count_env", n_env, 8);
        chk("count_adjacent", n_adj, 0);

        // Power off in the middle of step 5
        sfs_if.I_CH_ON = 4'b1010;
        repeat (21) cyc();
        chk("mid5_step", sfs_if.O_STEP, 5);
        sfs_if.I_MASTER_EN = 1'b0;
        cyc();
        chk("off5_still_running", sfs_if.O_RUNNING, 1);
        chk("off5_no_chreset_yet", sfs_if.O_CH_RESET, 0);
        cyc();
        chk("off5_clear_chreset", sfs_if.O_CH_RESET, 1);
        chk("off5_clear_running", sfs_if.O_RUNNING, 0);
        chk("off5_clear_step", sfs_if.O_STEP, 0);
        chk("off5_clear_state", sfs_if.state_dbg, 2);
        chk("off5_nr52", sfs_if.O_NR52, 8'h7A);
        cyc();
        chk("off5_off_chreset", sfs_if.O_CH_RESET, 0);
        chk("off5_off_state", sfs_if.state_dbg, 0);
        for (int c = 0; c < 12; c++) begin
            cyc();
            chk("off_quiet_step", sfs_if.O_STEP, 0);
            chk("off_quiet_ticks", {sfs_if.O_LENGTH_TICK, sfs_if.O_SWEEP_TICK, sfs_if.O_ENV_TICK}, 0);
            chk("off_quiet_chreset", sfs_if.O_CH_RESET, 0);
        end

        // Power off landing exactly on the wrap into step 2
        sfs_if.I_MASTER_EN = 1'b1;
        repeat (2) cyc();
        chk("w2_entry_running", sfs_if.O_RUNNING, 1);
        repeat (6) cyc();
        sfs_if.I_MASTER_EN = 1'b0;
        cyc();
        chk("w2_pre_step", sfs_if.O_STEP, 1);
        chk("w2_pre_running", sfs_if.O_RUNNING, 1);
        cyc();
        chk("w2_clear_chreset", sfs_if.O_CH_RESET, 1);
        chk("w2_no_len", sfs_if.O_LENGTH_TICK, 0);
        chk("w2_no_sweep", sfs_if.O_SWEEP_TICK, 0);
        chk("w2_clear_step", sfs_if.O_STEP, 0);
        cyc();
        chk("w2_off_state", sfs_if.state_dbg, 0);
        chk("w2_off_chreset", sfs_if.O_CH_RESET, 0);
        chk("w2_off_ticks", {sfs_if.O_LENGTH_TICK, sfs_if.O_SWEEP_TICK, sfs_if.O_ENV_TICK}, 0);

        // Re-enable one cycle after a disable: edge lands in CLEAR, acted on in OFF
        sfs_if.I_MASTER_EN = 1'b1;
        repeat (2) cyc();
        chk("re_entry_running", sfs_if.O_RUNNING, 1);
        repeat (3) cyc();
        sfs_if.I_MASTER_EN = 1'b0;
        cyc();
        chk("re_fall_running", sfs_if.O_RUNNING, 1);
        sfs_if.I_MASTER_EN = 1'b1;
        cyc();
        chk("re_clear_chreset", sfs_if.O_CH_RESET, 1);
        cyc();
        chk("re_off_state", sfs_if.state_dbg, 0);
        chk("re_off_chreset", sfs_if.O_CH_RESET, 0);
        cyc();
        chk("re_run_running", sfs_if.O_RUNNING, 1);
        chk("re_run_step", sfs_if.O_STEP, 0);

        // Reset mid-RUN with master still enabled
        repeat (5) cyc();
        chk("pre_rst_step", sfs_if.O_STEP, 1);
        rst = 1'b1;
        cyc();
        chk("mrst_running", sfs_if.O_RUNNING, 0);
        chk("mrst_step", sfs_if.O_STEP, 0);
        chk("mrst_chreset", sfs_if.O_CH_RESET, 0);
        chk("mrst_nr52", sfs_if.O_NR52, 8'h7A);
        rst = 1'b0;
        cyc();
        chk("mrst_q_running", sfs_if.O_RUNNING, 0);
        chk("mrst_q_chreset", sfs_if.O_CH_RESET, 0);
        cyc();
        chk("mrst_entry_running", sfs_if.O_RUNNING, 1);
        chk("mrst_entry_step", sfs_if.O_STEP, 0);
        for (int c = 1; c <= 8; c++) begin
            cyc();
            chk("mrst_first_len", sfs_if.O_LENGTH_TICK, c == 8);
            chk("mrst_step_seq", sfs_if.O_STEP, 3'(c / 4));
            chk("mrst_no_chreset", sfs_if.O_CH_RESET, 0);
        end

        // NR52 status byte
        sfs_if.I_CH_ON = 4'b0101;
        #1;
        chk("nr52_on", sfs_if.O_NR52, 8'hF5);
        sfs_if.I_MASTER_EN = 1'b0;
        cyc();
        chk("nr52_off", sfs_if.O_NR52, 8'h75);
        cyc();
        chk("nr52_clear_chreset", sfs_if.O_CH_RESET, 1);
        cyc();
        chk("nr52_final_state", sfs_if.state_dbg, 0);
        chk("nr52_final_nr52", sfs_if.O_NR52, 8'h75);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sound_frame_sequencer.md
Name: sound_frame_sequencer

Overview:
Central timing controller for the four sound channels. It divides I_CLK into a 512 Hz frame step and runs the 8-step frame sequence. It issues one-cycle length (256 Hz), sweep (128 Hz) and envelope (64 Hz) tick pulses that the channel blocks consume instead of counting their own long intervals. It also owns the NR52 master-enable sequencing: the power-off clear pulse, restart alignment and the status byte.

Parameters:
STEP_DIV, 8192, I_CLK cycles per frame step (4.194304 MHz / 512); legal range 2..65535.
DIV_W, 16, width of the divider counter; must satisfy 2^DIV_W >= STEP_DIV.

Ports:
I_CLK  input  1  system clock.
I_RESET  input  1  synchronous, active-high reset.
I_MASTER_EN  input  1  NR52 bit 7 (sound master enable), level.
I_CH_ON  input  4  per-channel active flags {ch4,ch3,ch2,ch1}, level.
O_LENGTH_TICK  output  1  one-cycle pulse, 256 Hz, clocks channel length counters.
O_SWEEP_TICK  output  1  one-cycle pulse, 128 Hz, clocks ch1 frequency sweep.
O_ENV_TICK  output  1  one-cycle pulse, 64 Hz, clocks volume envelopes.
O_STEP  output  3  current frame step 0..7.
O_CH_RESET  output  1  one-cycle pulse; channels clear all sound registers and stop.
O_NR52  output  8  NR52 read value {master_en, 3'b111, I_CH_ON}.
O_RUNNING  output  1  high while the sequencer is in RUN.

Behaviour:
- Reset values: divider 0, O_STEP 0, all ticks 0, O_CH_RESET 0, O_RUNNING 0, state OFF. O_NR52 is combinational from the registered master_en (reset 0) and I_CH_ON.
- master_en_q is a registered copy of I_MASTER_EN. The state machine acts on the edges of master_en_q against its previous value.
- State OFF:
  - divider and step held at 0; ticks held at 0.
  - Rising edge of master_en_q -> RUN, with divider=0 and step=0.
- State RUN:
  - O_RUNNING=1.
  - Each cycle the divider increments.
  - When divider==STEP_DIV-1: divider wraps to 0 and step increments mod 8 (7 -> 0) on the same edge.
  - Ticks are registered and high for exactly the one cycle after the wrap edge, decoded from the new step value:
    - O_LENGTH_TICK when new step is 0, 2, 4 or 6.
    - O_SWEEP_TICK when new step is 2 or 6.
    - O_ENV_TICK when new step is 7.
  - No tick is ever issued on the RUN entry cycle.
  - Falling edge of master_en_q -> CLEAR.
- State CLEAR:
  - Lasts exactly 1 cycle. O_CH_RESET=1, O_RUNNING=0, ticks 0, divider and step forced to 0.
  - Next state is OFF unconditionally. If the master is re-enabled during CLEAR, the rising edge is seen in OFF the following cycle.
- Tick rates in RUN: length 4 per 8 steps, sweep 2 per 8, envelope 1 per 8. The first length tick occurs 2*STEP_DIV cycles after RUN entry.
- Simultaneous events:
  - A wrap coinciding with a falling master edge: the falling edge wins. Go to CLEAR and suppress the tick.
  - I_RESET overrides everything, including CLEAR. No O_CH_RESET pulse is generated by I_RESET; channels see I_RESET directly.
- Reset mid-operation returns to OFF with step 0. If I_MASTER_EN is still high after reset, master_en_q rises one cycle later and RUN is entered cleanly.
- O_NR52 bits 6:4 always read 1. Bits 3:0 pass I_CH_ON through unchanged, and are 0 only because the channels clear them after O_CH_RESET.

Test Plan:
- STEP_DIV=4, assert I_MASTER_EN after reset -> O_RUNNING=1 two cycles later. O_STEP sequence 1,2,...,7,0 advances every 4 cycles. O_LENGTH_TICK at steps 2,4,6,0; O_SWEEP_TICK at 2,6; O_ENV_TICK at 7; each exactly 1 cycle wide.
- STEP_DIV=4, run 64 steps -> exactly 32 length, 16 sweep and 8 envelope pulses. No two pulses of the same type are adjacent.
- Drop I_MASTER_EN mid-step 5 -> O_CH_RESET high exactly one cycle, then OFF with O_STEP=0 and no further ticks. O_NR52 = 8'h70 | I_CH_ON.
- Drop I_MASTER_EN on the exact wrap cycle into step 2 -> no length or sweep tick; CLEAR then OFF.
- Re-enable 1 cycle after disable, then I_RESET mid-RUN -> the sequencer restarts from step 0. The first length tick comes 2*STEP_DIV cycles after RUN entry. No O_CH_RESET is emitted for the reset.
- I_CH_ON=4'b0101, master on -> O_NR52 = 8'hF5. With master off -> O_NR52 = 8'h75.
